// File: rtl/open_bank_tracker_if.sv
// Request-side bus of the open-row tracker: operation classify/commit, refresh,
// replay, and the idle-close request/acknowledge pair towards the command sequencer.
interface open_bank_tracker_if #(
    parameter int unsigned ROW_W  = 14,
    parameter int unsigned BANK_W = 3,
    parameter int unsigned RANK_W = 2
);
    logic [ROW_W-1:0]         row;
    logic [BANK_W-1:0]        bank;
    logic [RANK_W-1:0]        rank;
    logic                     doOp;
    logic                     doRefresh;
    logic [RANK_W-1:0]        refRank;
    logic                     redoValid;
    logic [2:0]               numOps;
    logic                     opValid;
    logic                     closeReq;
    logic [RANK_W-1:0]        closeRank;
    logic [BANK_W-1:0]        closeBank;
    logic                     closeAck;
    logic [RANK_W+BANK_W:0]   openCount;

    modport master (
        output row, bank, rank, doOp, doRefresh, refRank, redoValid, closeAck,
        input  numOps, opValid, closeReq, closeRank, closeBank, openCount
    );

    modport slave (
        input  row, bank, rank, doOp, doRefresh, refRank, redoValid, closeAck,
        output numOps, opValid, closeReq, closeRank, closeBank, openCount
    );
endinterface

// File: rtl/open_bank_tracker.sv
// Per-(rank, bank) open-row table with hit/miss/conflict classification, rank refresh,
// replay re-validation and an idle-close engine that requests precharge of stale banks.
module open_bank_tracker #(
    parameter int unsigned ROW_W    = 14,
    parameter int unsigned BANK_W   = 3,
    parameter int unsigned RANK_W   = 2,
    parameter int unsigned IDLE_CYC = 64,
    parameter int unsigned TMR_W    = 7
) (
    input logic                 CLK,
    input logic                 Reset_n,
    open_bank_tracker_if.slave  bus
);
    localparam int unsigned IW = RANK_W + BANK_W;
    localparam int unsigned E  = 1 << IW;

    typedef enum logic {StScan, StReq} state_e;

    logic [ROW_W-1:0] row_q [E];
    logic [TMR_W-1:0] tmr_q [E];
    logic [TMR_W-1:0] tmr_d [E];
    logic [E-1:0]     valid_q, valid_d;
    logic [E-1:0]     ref_sel, op_sel, ack_sel, redo_sel;
    logic [IW-1:0]    op_idx, last_q, ptr_q, close_idx_q;
    logic [IW:0]      pop;
    state_e           state_q;
    logic             close_req_q, op_valid_q;
    logic [2:0]       num_ops_q, num_ops_d;
    logic             withdraw, ack_eff, ptr_expired;

    assign op_idx = {bus.rank, bus.bank};

    // A request whose entry is refreshed or re-opened is dropped; any ack that cycle is moot.
    assign withdraw = (state_q == StReq) && (ref_sel[close_idx_q] || op_sel[close_idx_q]);
    assign ack_eff  = (state_q == StReq) && bus.closeAck && !withdraw;

    always_comb begin
        ref_sel  = '0;
        op_sel   = '0;
        ack_sel  = '0;
        redo_sel = '0;
        valid_d  = valid_q;
        pop      = '0;
        for (int i = 0; i < int'(E); i++) begin
            ref_sel[i]  = bus.doRefresh && ((i >> BANK_W) == int'(bus.refRank));
            op_sel[i]   = bus.doOp && (op_idx == IW'(i));
            ack_sel[i]  = ack_eff && (close_idx_q == IW'(i));
            redo_sel[i] = bus.redoValid && (last_q == IW'(i));
            tmr_d[i]    = tmr_q[i];
            if (ref_sel[i]) begin
                valid_d[i] = 1'b0;
                tmr_d[i]   = '0;
            end else if (op_sel[i]) begin
                valid_d[i] = 1'b1;
                tmr_d[i]   = '0;
            end else if (ack_sel[i]) begin
                valid_d[i] = 1'b0;
                tmr_d[i]   = '0;
            end else if (redo_sel[i]) begin
                valid_d[i] = 1'b1;
                tmr_d[i]   = '0;
            end else if (valid_q[i] && (tmr_q[i] < TMR_W'(IDLE_CYC))) begin
                tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end
            pop = pop + (IW + 1)'(valid_q[i]);
        end
    end

    always_comb begin
        if (!valid_q[op_idx]) begin
            num_ops_d = 3'b010;
        end else if (row_q[op_idx] == bus.row) begin
            num_ops_d = 3'b001;
        end else begin
            num_ops_d = 3'b100;
        end
    end

    // An entry being refreshed or re-opened this cycle is no longer a close candidate.
    assign ptr_expired = (IDLE_CYC != 0) && valid_q[ptr_q]
                         && (tmr_q[ptr_q] == TMR_W'(IDLE_CYC))
                         && !ref_sel[ptr_q] && !op_sel[ptr_q];

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(E); i++) begin
                row_q[i] <= '0;
                tmr_q[i] <= '0;
            end
            valid_q     <= '0;
            last_q      <= '0;
            ptr_q       <= '0;
            close_idx_q <= '0;
            state_q     <= StScan;
            close_req_q <= 1'b0;
            op_valid_q  <= 1'b0;
            num_ops_q   <= '0;
            bus.openCount <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(E); i++) begin
                tmr_q[i] <= tmr_d[i];
                if (op_sel[i] && !ref_sel[i]) begin
                    row_q[i] <= bus.row;
                end
            end
            op_valid_q <= bus.doOp;
            if (bus.doOp) begin
                num_ops_q <= num_ops_d;
                last_q    <= op_idx;
            end
            bus.openCount <= pop;
            unique case (state_q)
                StScan: begin
                    if (ptr_expired) begin
                        close_idx_q <= ptr_q;
                        close_req_q <= 1'b1;
                        state_q     <= StReq;
                    end else begin
                        ptr_q <= ptr_q + IW'(1);
                    end
                end
                StReq: begin
                    if (withdraw || bus.closeAck) begin
                        close_req_q <= 1'b0;
                        ptr_q       <= close_idx_q + IW'(1);
                        state_q     <= StScan;
                    end
                end
            endcase
        end
    end

    assign bus.numOps    = num_ops_q;
    assign bus.opValid   = op_valid_q;
    assign bus.closeReq  = close_req_q;
    assign bus.closeRank = close_idx_q[IW-1:BANK_W];
    assign bus.closeBank = close_idx_q[BANK_W-1:0];
endmodule

// File: doc/open_bank_tracker.md
# open_bank_tracker

Parametrised open-row tracker for the DDR2/DDR3 RDIMM memory controller. It keeps one row register and valid bit per (rank, bank) and classifies each operation as hit, no-conflict miss or conflict one cycle later. It clears whole ranks on refresh and re-validates an entry after a replayed operation. An idle-close engine watches per-bank idle timers and asks the command sequencer to precharge banks that have stayed open too long. It sits between the request queue and the command sequencer.

## Interface
- ROW_W, 14, row address width
- BANK_W, 3, bank address width (2^BANK_W banks per rank)
- RANK_W, 2, rank select width (2^RANK_W ranks)
- IDLE_CYC, 64, idle cycles before a close request; 0 disables idle close
- TMR_W, 7, idle timer width; must satisfy IDLE_CYC < 2^TMR_W
- Derived: E = 2^(RANK_W+BANK_W) entries; entry index = {rank, bank}
- CLK  in  1  clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- row  in  ROW_W  row of the current operation
- bank  in  BANK_W  bank of the current operation
- rank  in  RANK_W  rank of the current operation
- doOp  in  1  classify and commit the current operation
- doRefresh  in  1  invalidate all entries of refRank
- refRank  in  RANK_W  rank being refreshed
- redoValid  in  1  re-set the valid bit of the last committed entry
- numOps  out  3  one-hot class: 001 hit, 010 no-conflict miss, 100 conflict
- opValid  out  1  numOps is valid; a one-cycle pulse
- closeReq  out  1  idle-close request
- closeRank  out  RANK_W  rank to precharge
- closeBank  out  BANK_W  bank to precharge
- closeAck  in  1  sequencer has issued the precharge for closeRank/closeBank
- openCount  out  RANK_W+BANK_W+1  number of valid entries

## Operation
- Classification, evaluated on the entry {rank, bank} when doOp = 1:
  - hit: valid and stored row == row
  - conflict: valid and stored row != row
  - no-conflict miss: entry not valid
- Commit on doOp: store the row, set the valid bit, clear the entry's idle timer, and latch {rank, bank} as lastEntry.
- Refresh (doRefresh): clear the valid bits of all 2^BANK_W entries of refRank and clear their timers.
- redoValid: set valid[lastEntry]. The stored row is unchanged.
- closeAck: clear the valid bit of the requested entry.
- Priority of valid-bit writes within one cycle, highest first: Reset_n, refresh, doOp, closeAck, redoValid.
  - An entry touched by a higher-priority event ignores the lower-priority ones in that cycle.
  - Events that touch different entries all take effect in the same cycle.
- Idle timers, one per entry, TMR_W bits:
  - count up while the entry is valid and not touched this cycle
  - saturate at IDLE_CYC
  - an entry is expired when valid and timer == IDLE_CYC
- Close engine, two states:
  - SCAN: a pointer ptr steps through entries 0..E-1, one per cycle, wrapping from E-1 to 0. If entry ptr is expired, latch closeRank/closeBank = ptr, raise closeReq and go to REQ.
  - REQ: closeReq and the close address are held stable until closeAck = 1. Then drop closeReq, set ptr = latched index + 1 (wrapping), and return to SCAN.
  - If the requested entry is invalidated by refresh or re-opened by doOp while in REQ, the request is withdrawn: closeReq falls next cycle and the engine returns to SCAN.
  - A closeAck that arrives while the request is withdrawn is ignored.
  - With IDLE_CYC = 0 the engine stays in SCAN and closeReq is never raised.
- openCount is the registered population count of the valid bits.

## Timing
- Reset values: all valid bits 0, timers 0, ptr 0, state SCAN, numOps 000, opValid 0, closeReq 0, closeRank 0, closeBank 0, openCount 0, lastEntry 0.
- Reset_n asserted mid-operation aborts everything immediately. There is no pending state after release.
- doOp in cycle N: numOps is valid with opValid = 1 in cycle N+1, classified against the table state before the edge at the end of N.
  - Back-to-back doOp to the same entry: the second sees the row committed by the first.
  - numOps holds its value when opValid = 0.
- doRefresh in cycle N: the cleared entries read as invalid for a doOp in cycle N+1.
  - doOp and doRefresh in the same cycle on the same rank: numOps classifies against the pre-refresh state, and the entry ends invalid.
- An entry opened or touched at cycle N becomes expired after IDLE_CYC further untouched cycles. The scan adds up to E cycles before closeReq rises.
- closeAck in cycle N: the entry is invalid and closeReq is low in cycle N+1. The earliest next closeReq is cycle N+2.
- openCount lags valid-bit changes by one cycle.

## Test plan
- Reset, then doOp rank 1, bank 5, row 0x123 -> numOps 010; repeat with the same row -> 001; repeat with row 0x124 -> 100; openCount 1.
- Open bank 0 on each of the 4 ranks, doRefresh refRank 2 -> openCount goes from 4 to 3; doOp rank 2, bank 0 -> 010; rank 1 -> 001.
- IDLE_CYC = 8, open entry 3, no further traffic -> closeReq rises with closeRank 0, closeBank 3 within 8 + 32 cycles; held 5 cycles with no ack; closeAck -> closeReq low next cycle, entry invalid, next doOp -> 010.
- Pending close on entry 3, doOp to entry 3 -> request withdrawn next cycle, entry stays valid, timer restarts; a late closeAck is ignored.
- doOp entry 9 row 0x7, doRefresh that rank, redoValid -> next doOp entry 9 row 0x7 -> 001.
- Assert Reset_n low with closeReq high and 10 entries open -> all outputs 0 immediately; after release, doOp to any entry -> 010.
